clock_reconfig_seq: RTL and testbench
=====================================

# clock_reconfig_seq

Sequencer that owns the `reconfig_en` line of the millisecond/second/minute/hour counter chain in the UART-controlled clock. It accepts a set-time request from the UART command decoder and range-checks it. It freezes and clears the counter chain, optionally drives the PLL reconfiguration handshake and waits for lock, then loads the new time and releases the counters. Exactly one request is in flight at a time.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `LOCK_TIMEOUT_MS`, 10: maximum wait for PLL idle+lock; `TIMEOUT_CYC = CLK_HZ/1000*LOCK_TIMEOUT_MS` (500_000).
- `FREEZE_CYC`, 2: cycles `reconfig_en` is held before load/PLL step (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state and outputs to reset values.
- `req_valid` in 1: set-time request valid.
- `req_ready` out 1: high only in IDLE; transfer when `req_valid && req_ready`.
- `req_hour` in 5, `req_min` in 6, `req_sec` in 6: requested time, sampled on transfer.
- `pll_start` out 1: one-cycle PLL reconfiguration start pulse.
- `pll_busy` in 1, `pll_locked` in 1: PLL reconfig status (synchronous to `clk`).
- `reconfig_en` out 1: freeze/clear to counter chain.
- `load_en` out 1: one-cycle load strobe; `load_hour` out 5, `load_min` out 6, `load_sec` out 6: latched values.
- `done` out 1: one-cycle completion pulse; `err` out 1: one-cycle error pulse; `err_code` out 2: 0 none, 1 range, 2 timeout, held until next transfer.

## Operation
- States: IDLE, FREEZE, PLL_START, PLL_WAIT, LOAD, RELEASE.
- IDLE: `req_ready`=1. On transfer, latch fields and clear `err_code`.
  - If hour>23, min>59 or sec>59: `err`=1 for 1 cycle, `err_code`=1, stay IDLE. The counters are not touched.
  - Else go to FREEZE.
- FREEZE: `reconfig_en`=1; a counter runs FREEZE_CYC cycles.
  - Then go to PLL_START (macro on) or LOAD (macro off).
- PLL_START: `pll_start`=1 for one cycle, clear the timeout counter, go to PLL_WAIT.
- PLL_WAIT: exit to LOAD when `!pll_busy && pll_locked`.
  - If the timeout counter reaches TIMEOUT_CYC-1 without exit: `err`=1, `err_code`=2, go to RELEASE without loading.
  - If lock and timeout occur in the same cycle, lock wins.
- LOAD: `load_en`=1 for one cycle with latched values, `reconfig_en` still 1.
- RELEASE: `reconfig_en`=0. `done`=1 only if LOAD was executed. Go to IDLE.
- `reconfig_en` is 1 in FREEZE, PLL_START, PLL_WAIT and LOAD; 0 elsewhere.
- Timeout counter width is `$clog2(TIMEOUT_CYC+1)` and saturates.

## Timing
- Reset values:
  - `req_ready`=0 during reset, 1 the first cycle after release.
  - All other outputs 0; `load_*`=0; state IDLE.
- Reset mid-sequence drops `reconfig_en` asynchronously; no `done` or `err` is issued.
- Latency, transfer edge to `load_en` (macro off): FREEZE_CYC+1 cycles. `done` follows `load_en` by 1 cycle.
- Macro on: adds 1 cycle (PLL_START) plus N cycles in PLL_WAIT.
- `req_valid` held while busy is ignored until IDLE; a new transfer can occur in the IDLE cycle after RELEASE.
- `pll_locked` already high with `pll_busy` low in the first PLL_WAIT cycle: exit after exactly 1 PLL_WAIT cycle.

## Configuration
- `CLOCK_RECONF_PLL_EN` defined: PLL_START/PLL_WAIT are compiled in, as are the timeout counter and error code 2.
- Not defined:
  - `pll_start` is tied 0; `pll_busy` and `pll_locked` are unused.
  - FREEZE goes directly to LOAD; `err_code` 2 never occurs.

## Structure
- Shared package `clock_pkg`:
  - State enum.
  - `err_code` localparams.
  - Time field widths and limits: HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
- One sub-module `timeout_counter` (enable, clear, terminal flag) is natural. Everything else is a single FSM in `clock_reconfig_seq`.

## Test plan
- Macro off, request 12:34:56: `reconfig_en` high for 3 cycles; `load_en` 3 cycles after transfer with 12/34/56; `done` 1 cycle later.
- Request 24:00:00 or 10:60:00: `err` pulse, `err_code`=1, `reconfig_en` never asserts, `req_ready` stays 1.
- Macro on, `pll_locked` rises 100 cycles after `pll_start` with `pll_busy`=0: `load_en` follows; `done`=1, `err_code`=0.
- Macro on, lock never rises, TIMEOUT_CYC=1000 (override): `err` after 1000 PLL_WAIT cycles, `err_code`=2, no `load_en`, no `done`, `reconfig_en` drops.
- Async `reset` pulse in PLL_WAIT: `reconfig_en`=0 immediately; IDLE with `req_ready`=1 after release.
- `req_valid` held continuously across two requests: second transfer happens exactly in the cycle after RELEASE.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: state encoding, error codes and time-field limits shared by the
// reconfiguration sequencer, its bus interface and the bench.
package clock_pkg;

    localparam int unsigned HOUR_W = 32'd5;
    localparam int unsigned MIN_W  = 32'd6;
    localparam int unsigned SEC_W  = 32'd6;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FREEZE    = 3'd1,
        ST_PLL_START = 3'd2,
        ST_PLL_WAIT  = 3'd3,
        ST_LOAD      = 3'd4,
        ST_RELEASE   = 3'd5
    } seq_state_t;

    function automatic logic time_in_range(
        input logic [HOUR_W-1:0] hour,
        input logic [MIN_W-1:0]  min,
        input logic [SEC_W-1:0]  sec
    );
        return (hour <= HOUR_MAX) && (min <= MIN_MAX) && (sec <= SEC_MAX);
    endfunction

endpackage

// File: rtl/clock_reconfig_seq_if.sv
// clock_reconfig_seq_if: set-time request channel, PLL handshake and counter-chain
// control bundled together; slave is the sequencer side, master the surrounding logic.
interface clock_reconfig_seq_if;
    import clock_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [HOUR_W-1:0] req_hour;
    logic [MIN_W-1:0]  req_min;
    logic [SEC_W-1:0]  req_sec;
    logic              pll_start;
    logic              pll_busy;
    logic              pll_locked;
    logic              reconfig_en;
    logic              load_en;
    logic [HOUR_W-1:0] load_hour;
    logic [MIN_W-1:0]  load_min;
    logic [SEC_W-1:0]  load_sec;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    modport master (
        output req_valid, req_hour, req_min, req_sec, pll_busy, pll_locked,
        input  req_ready, pll_start, reconfig_en, load_en, load_hour, load_min,
               load_sec, done, err, err_code
    );

    modport slave (
        input  req_valid, req_hour, req_min, req_sec, pll_busy, pll_locked,
        output req_ready, pll_start, reconfig_en, load_en, load_hour, load_min,
               load_sec, done, err, err_code
    );

endinterface

// File: rtl/timeout_counter.sv
// timeout_counter: saturating cycle counter with synchronous clear; o_term flags
// the LIMIT-th enabled cycle since the last clear.
module timeout_counter #(
    parameter int unsigned LIMIT = 32'd500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_term
);

    localparam int unsigned W = $clog2(LIMIT + 32'd1);

    logic [W-1:0] r_cnt;

    // Count enabled cycles, holding at LIMIT so a long stall cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != W'(LIMIT))) begin
            r_cnt <= r_cnt + W'(32'd1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_term = (r_cnt == W'(LIMIT - 32'd1));

endmodule

// File: rtl/clock_reconfig_seq.sv
// clock_reconfig_seq: owns reconfig_en of the time counter chain; range-checks a set-time
// request, freezes the chain, optionally reconfigures the PLL (CLOCK_RECONF_PLL_EN), then loads.
module clock_reconfig_seq
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 32'd50_000_000,
    parameter int unsigned LOCK_TIMEOUT_MS = 32'd10,
    parameter int unsigned FREEZE_CYC      = 32'd2,
    parameter int unsigned TIMEOUT_CYC     = CLK_HZ / 32'd1000 * LOCK_TIMEOUT_MS
) (
    input  logic clk,
    input  logic reset,
    clock_reconfig_seq_if.slave bus
);

    localparam int unsigned FRZ_W = (FREEZE_CYC > 32'd1) ? $clog2(FREEZE_CYC) : 32'd1;
    localparam logic [FRZ_W-1:0] FRZ_LAST = FRZ_W'(FREEZE_CYC - 32'd1);

    seq_state_t        r_state;
    logic [FRZ_W-1:0]  r_frz_cnt;
    logic [HOUR_W-1:0] r_hour;
    logic [MIN_W-1:0]  r_min;
    logic [SEC_W-1:0]  r_sec;
    logic              r_req_ready;
    logic              r_reconfig_en;
    logic              r_load_en;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic              w_req_fire;
    logic              w_req_ok;

    assign w_req_fire = bus.req_valid & r_req_ready;
    assign w_req_ok   = time_in_range(bus.req_hour, bus.req_min, bus.req_sec);

`ifdef CLOCK_RECONF_PLL_EN
    logic r_pll_start;
    logic w_pll_ready;
    logic w_to_en;
    logic w_to_clr;
    logic w_to_term;

    assign w_pll_ready = ~bus.pll_busy & bus.pll_locked;
    assign w_to_en     = (r_state == ST_PLL_WAIT);
    assign w_to_clr    = (r_state == ST_PLL_START);

    timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_to_en),
        .i_clr  (w_to_clr),
        .o_term (w_to_term)
    );

    assign bus.pll_start = r_pll_start;
`else
    localparam int unsigned UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;
    logic w_unused_pll;

    assign w_unused_pll  = bus.pll_busy ^ bus.pll_locked;
    assign bus.pll_start = 1'b0;
`endif

    // Sequencer FSM; every output is a register updated together with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_frz_cnt     <= '0;
            r_hour        <= '0;
            r_min         <= '0;
            r_sec         <= '0;
            r_req_ready   <= 1'b0;
            r_reconfig_en <= 1'b0;
            r_load_en     <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
`ifdef CLOCK_RECONF_PLL_EN
            r_pll_start   <= 1'b0;
`endif
        end else begin
            r_load_en <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef CLOCK_RECONF_PLL_EN
            r_pll_start <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_hour <= bus.req_hour;
                        r_min  <= bus.req_min;
                        r_sec  <= bus.req_sec;
                        // A bad time is rejected without ever touching the counters.
                        if (w_req_ok) begin
                            r_state       <= ST_FREEZE;
                            r_frz_cnt     <= '0;
                            r_reconfig_en <= 1'b1;
                            r_req_ready   <= 1'b0;
                            r_err_code    <= ERR_NONE;
                        end else begin
                            r_err         <= 1'b1;
                            r_err_code    <= ERR_RANGE;
                            r_req_ready   <= 1'b1;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_FREEZE: begin
                    if (r_frz_cnt == FRZ_LAST) begin
`ifdef CLOCK_RECONF_PLL_EN
                        r_state     <= ST_PLL_START;
                        r_pll_start <= 1'b1;
`else
                        r_state     <= ST_LOAD;
                        r_load_en   <= 1'b1;
`endif
                    end else begin
                        r_frz_cnt <= r_frz_cnt + FRZ_W'(32'd1);
                    end
                end
`ifdef CLOCK_RECONF_PLL_EN
                ST_PLL_START: begin
                    r_state <= ST_PLL_WAIT;
                end
                ST_PLL_WAIT: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (w_pll_ready) begin
                        r_state   <= ST_LOAD;
                        r_load_en <= 1'b1;
                    end else if (w_to_term) begin
                        r_state       <= ST_RELEASE;
                        r_reconfig_en <= 1'b0;
                        r_err         <= 1'b1;
                        r_err_code    <= ERR_TIMEOUT;
                    end else begin
                        r_state <= ST_PLL_WAIT;
                    end
                end
`endif
                ST_LOAD: begin
                    r_state       <= ST_RELEASE;
                    r_reconfig_en <= 1'b0;
                    r_done        <= 1'b1;
                end
                ST_RELEASE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_reconfig_en <= 1'b0;
                    r_req_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = r_req_ready;
    assign bus.reconfig_en = r_reconfig_en;
    assign bus.load_en     = r_load_en;
    assign bus.load_hour   = r_hour;
    assign bus.load_min    = r_min;
    assign bus.load_sec    = r_sec;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;

endmodule

// File: tb/tb_clock_reconfig_seq.sv
// tb_clock_reconfig_seq: directed bench for clock_reconfig_seq with a load-value scoreboard;
// the PLL scenarios are compiled in when CLOCK_RECONF_PLL_EN is defined.
module tb_clock_reconfig_seq;

    localparam int FREEZE_CYC = 32'd2;
    localparam int TO_CYC     = 32'd1000;
`ifdef CLOCK_RECONF_PLL_EN
    localparam int PLL_EXTRA  = 32'd2;
`else
    localparam int PLL_EXTRA  = 32'd0;
`endif
    localparam int LOAD_LAT   = FREEZE_CYC + 32'd1 + PLL_EXTRA;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } tval_t;

    typedef struct {
        int re_cnt;
        int load_first;
        int done_first;
        int err_first;
        int err_cnt;
        int rdy_first;
        int rdy_cnt;
    } obs_t;

    logic clk = 1'b0;
    logic reset;

    clock_reconfig_seq_if bus();

    clock_reconfig_seq #(
        .CLK_HZ          (32'd50_000_000),
        .LOCK_TIMEOUT_MS (32'd10),
        .FREEZE_CYC      (FREEZE_CYC),
        .TIMEOUT_CYC     (TO_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    tval_t exp_q[$];
    tval_t mon_e;
    int checks   = 0;
    int failures = 0;
    int n_load   = 0;
    int n_done   = 0;
    int n_err    = 0;

    logic [4:0] bad_h [4] = '{5'd24, 5'd10, 5'd10, 5'd31};
    logic [5:0] bad_m [4] = '{6'd0,  6'd60, 6'd0,  6'd63};
    logic [5:0] bad_s [4] = '{6'd0,  6'd0,  6'd60, 6'd63};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load strobe must match the oldest accepted in-range request.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.load_en === 1'b1) begin
                n_load++;
                chk("sb_load_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("sb_load_hour", 32'(bus.load_hour), 32'(mon_e.h));
                    chk("sb_load_min",  32'(bus.load_min),  32'(mon_e.m));
                    chk("sb_load_sec",  32'(bus.load_sec),  32'(mon_e.s));
                end
            end
            if (bus.done === 1'b1) n_done++;
            if (bus.err === 1'b1)  n_err++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input bit keep);
        int w = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_hour  = h;
        bus.req_min   = m;
        bus.req_sec   = s;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("send_ready_wait", 32'(w < 50), 32'd1);
        if (h <= 5'd23 && m <= 6'd59 && s <= 6'd59) exp_q.push_back({h, m, s});
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic observe(input int n, output obs_t o);
        o = '{default: 0};
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (bus.reconfig_en === 1'b1) o.re_cnt++;
            if (bus.load_en === 1'b1 && o.load_first == 0) o.load_first = c;
            if (bus.done === 1'b1 && o.done_first == 0) o.done_first = c;
            if (bus.err === 1'b1 && o.err_first == 0) o.err_first = c;
            if (bus.err === 1'b1) o.err_cnt++;
            if (bus.req_ready === 1'b1 && o.rdy_first == 0) o.rdy_first = c;
            if (bus.req_ready === 1'b1) o.rdy_cnt++;
        end
    endtask

    initial begin
        obs_t o;
        int w;
        int k;
        int ld_before;
        int exp_load = 0;
        int exp_done = 0;
        int exp_err  = 0;

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_hour   = 5'd0;
        bus.req_min    = 6'd0;
        bus.req_sec    = 6'd0;
        bus.pll_busy   = 1'b0;
`ifdef CLOCK_RECONF_PLL_EN
        bus.pll_locked = 1'b1;
`else
        bus.pll_locked = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req_ready",   32'(bus.req_ready),   32'd0);
        chk("rst_reconfig_en", 32'(bus.reconfig_en), 32'd0);
        chk("rst_load_en",     32'(bus.load_en),     32'd0);
        chk("rst_load_hour",   32'(bus.load_hour),   32'd0);
        chk("rst_done",        32'(bus.done),        32'd0);
        chk("rst_err",         32'(bus.err),         32'd0);
        chk("rst_err_code",    32'(bus.err_code),    32'd0);
        chk("rst_pll_start",   32'(bus.pll_start),   32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Nominal request 12:34:56.
        send(5'd12, 6'd34, 6'd56, 1'b0);
        observe(LOAD_LAT + 3, o);
        chk("nom_reconfig_cycles", o.re_cnt,     LOAD_LAT);
        chk("nom_load_latency",    o.load_first, LOAD_LAT);
        chk("nom_done_latency",    o.done_first, LOAD_LAT + 1);
        chk("nom_err_cnt",         o.err_cnt,    32'd0);
        chk("nom_ready_back",      o.rdy_first,  LOAD_LAT + 2);
        chk("nom_err_code",        32'(bus.err_code), 32'd0);
        exp_load++;
        exp_done++;

        // Out-of-range requests: rejected in IDLE, counters untouched.
        for (int i = 0; i < 4; i++) begin
            send(bad_h[i], bad_m[i], bad_s[i], 1'b0);
            observe(4, o);
            chk("rng_err_first",   o.err_first,  32'd1);
            chk("rng_err_pulse",   o.err_cnt,    32'd1);
            chk("rng_no_reconfig", o.re_cnt,     32'd0);
            chk("rng_no_load",     o.load_first, 32'd0);
            chk("rng_ready_held",  o.rdy_cnt,    32'd4);
            chk("rng_err_code",    32'(bus.err_code), 32'd1);
            exp_err++;
        end

        // Limit values are accepted and the stale error code is cleared.
        send(5'd23, 6'd59, 6'd59, 1'b0);
        observe(LOAD_LAT + 3, o);
        chk("max_load_latency", o.load_first, LOAD_LAT);
        chk("max_done_latency", o.done_first, LOAD_LAT + 1);
        chk("max_err_code_clr", 32'(bus.err_code), 32'd0);
        exp_load++;
        exp_done++;
        send(5'd0, 6'd0, 6'd0, 1'b0);
        observe(LOAD_LAT + 3, o);
        chk("zero_load_latency", o.load_first, LOAD_LAT);
        exp_load++;
        exp_done++;

        // Valid held across two requests: second transfer right after RELEASE.
        send(5'd1, 6'd2, 6'd3, 1'b1);
        bus.req_hour = 5'd21;
        bus.req_min  = 6'd43;
        bus.req_sec  = 6'd5;
        exp_q.push_back({5'd21, 6'd43, 6'd5});
        observe(LOAD_LAT + 2, o);
        chk("b2b_first_load", o.load_first, LOAD_LAT);
        chk("b2b_first_done", o.done_first, LOAD_LAT + 1);
        chk("b2b_ready_idle", o.rdy_first,  LOAD_LAT + 2);
        @(negedge clk);
        chk("b2b_second_xfer",     32'(bus.req_ready),   32'd0);
        chk("b2b_second_reconfig", 32'(bus.reconfig_en), 32'd1);
        bus.req_valid = 1'b0;
        observe(LOAD_LAT + 1, o);
        chk("b2b_second_done", o.done_first, LOAD_LAT);
        exp_load += 2;
        exp_done += 2;

`ifdef CLOCK_RECONF_PLL_EN
        // Lock arrives 100 cycles after the PLL start pulse.
        bus.pll_locked = 1'b0;
        send(5'd8, 6'd15, 6'd30, 1'b0);
        w = 0;
        while (bus.pll_start !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("lock_pll_start_seen", 32'(w < 20), 32'd1);
        repeat (100) @(negedge clk);
        bus.pll_locked = 1'b1;
        w = 0;
        while (bus.load_en !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("lock_to_load", w, 32'd1);
        @(negedge clk);
        chk("lock_done",     32'(bus.done),     32'd1);
        chk("lock_err_code", 32'(bus.err_code), 32'd0);
        exp_load++;
        exp_done++;

        // Lock never arrives: timeout after TO_CYC PLL_WAIT cycles.
        bus.pll_locked = 1'b0;
        send(5'd7, 6'd0, 6'd0, 1'b0);
        w = 0;
        while (bus.pll_start !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        chk("to_pll_start_seen", 32'(w < 20), 32'd1);
        ld_before = n_load;
        k = 0;
        while (bus.err !== 1'b1 && k < TO_CYC + 50) begin @(negedge clk); k++; end
        chk("to_wait_cycles",  k, TO_CYC + 1);
        chk("to_reconfig_off", 32'(bus.reconfig_en), 32'd0);
        chk("to_err_code",     32'(bus.err_code),    32'd2);
        chk("to_no_done",      32'(bus.done),        32'd0);
        chk("to_no_load",      n_load, ld_before);
        @(negedge clk);
        chk("to_err_pulse",     32'(bus.err),       32'd0);
        chk("to_err_code_held", 32'(bus.err_code),  32'd2);
        chk("to_ready_back",    32'(bus.req_ready), 32'd1);
        exp_q.delete();
        exp_err++;
        bus.pll_locked = 1'b0;
`endif

        // Asynchronous reset in the middle of a sequence.
        send(5'd9, 6'd9, 6'd9, 1'b0);
`ifdef CLOCK_RECONF_PLL_EN
        w = 0;
        while (bus.pll_start !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        repeat (3) @(negedge clk);
`else
        @(negedge clk);
`endif
        chk("rstmid_pre_reconfig", 32'(bus.reconfig_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_reconfig_drop", 32'(bus.reconfig_en), 32'd0);
        chk("rstmid_ready_low",     32'(bus.req_ready),   32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
`ifdef CLOCK_RECONF_PLL_EN
        bus.pll_locked = 1'b1;
`endif
        @(negedge clk);
        chk("rstmid_ready_after", 32'(bus.req_ready),   32'd1);
        chk("rstmid_reconfig_off", 32'(bus.reconfig_en), 32'd0);

        // Recovery after the reset.
        send(5'd17, 6'd45, 6'd0, 1'b0);
        observe(LOAD_LAT + 3, o);
        chk("recov_load_latency", o.load_first, LOAD_LAT);
        chk("recov_done_latency", o.done_first, LOAD_LAT + 1);
        exp_load++;
        exp_done++;

        @(negedge clk);
        chk("total_load",  n_load, exp_load);
        chk("total_done",  n_done, exp_done);
        chk("total_err",   n_err,  exp_err);
        chk("sb_drained",  32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
